alu_add_sched: RTL and testbench
================================

Name: alu_add_sched

Overview:
- Shares one alu_add instance between NumReq independent requesters, such as keypad-entry, memory-recall and repeat-equals paths.
- Accepts one request at a time using round-robin arbitration and drives the operands into alu_add over its valid/ready handshake.
- Captures the sum and returns it only to the requester that issued the operation.
- Sits between the calculator control logic and the single adder datapath.

Parameters:
- NumReq, 4, number of requesters (≥2).
- IdxW, $clog2(NumReq), requester index width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is synchronous and active-low.
- req_left_i  in  NumReq x num_t  per-requester left operand.
- req_right_i  in  NumReq x num_t  per-requester right operand.
- req_valid_i  in  NumReq  request valid.
- req_ready_o  out  NumReq  request accepted (one-hot or zero).
- rsp_result_o  out  num_t  result bus, shared by all requesters.
- rsp_valid_o  out  NumReq  result valid (one-hot or zero).
- rsp_ready_i  in  NumReq  requester takes result.
- alu_left_o  out  num_t  to alu_add left_i.
- alu_right_o  out  num_t  to alu_add right_i.
- alu_in_valid_o  out  1  to alu_add in_valid_i.
- alu_in_ready_i  in  1  from alu_add in_ready_o.
- alu_result_i  in  num_t  from alu_add result_o.
- alu_out_valid_i  in  1  from alu_add out_valid_o.
- alu_out_ready_o  out  1  to alu_add out_ready_i.
- busy_o  out  1  state != IDLE.
- ops_done_o  out  32  completed-operation counter.

Behaviour:
- Reset (rst_ni=0 at posedge):
  - state=IDLE, last_grant=NumReq-1, so requester 0 wins first.
  - All valid/ready outputs 0, operand/result registers 0, ops_done_o=0, busy_o=0.
  - The integrator drives alu_add rst_i from !rst_ni.
  - Reset mid-operation drops the transaction; no response is ever produced for it.
- IDLE:
  - If any req_valid_i is set, pick the winner w as the first set bit scanning from last_grant+1 upward, wrapping.
  - Assert req_ready_o[w] combinationally in that cycle, register operands and owner=w, go to ISSUE.
  - No requests: stay in IDLE, all outputs 0.
- ISSUE:
  - alu_in_valid_o=1 and alu_left_o/alu_right_o come from the registers, held stable.
  - On alu_in_ready_i=1 go to WAIT.
- WAIT:
  - alu_out_ready_o=1.
  - On alu_out_valid_i=1 register alu_result_i and go to RESP.
- RESP:
  - rsp_valid_o[owner]=1 and rsp_result_o=the registered result, held stable until accepted.
  - On rsp_ready_i[owner]=1: last_grant←owner, ops_done_o+1 (wraps at 2^32), go to IDLE.
- Outside RESP, rsp_result_o holds its last value and rsp_valid_o=0.
- Latency:
  - Acceptance happens in cycle 0; alu_in_valid_o rises in cycle 1.
  - rsp_valid_o rises the cycle after alu_out_valid_i.
  - Minimum back-to-back issue interval is RESP→IDLE→ISSUE.
- Fairness: a continuously requesting requester waits at most NumReq-1 other operations.
- Requester protocol: req_valid_i must not drop, and operands must not change, until req_ready_o is seen. The bench asserts this; the RTL does not check it.
- Non-owner rsp_ready_i values are ignored. A requester may re-request while its own response is pending; it is arbitrated only after returning to IDLE.
- Error-flagged or subnormal operands and results pass through unmodified; the scheduler never inspects num_t fields.
- Invariants (asserted): req_ready_o, rsp_valid_o one-hot0; at most one of alu_in_valid_o, alu_out_ready_o, |rsp_valid_o set.

Decomposition:
- calc_pkg gains:
  - typedef sched_state_e {IDLE, ISSUE, WAIT, RESP};
  - a localparam for the default NumReq.
  - num_t is reused unchanged.
- Sub-module calc_rr_arbiter: combinational, parameter NumReq.
  - Inputs: req vector, last_grant.
  - Outputs: grant one-hot, grant_idx, any_req.
  - Reusable for future multiplier/divider schedulers.

Test Plan:
- Single requester: req 2 sends 1.5 + 2.25 → rsp_valid_o=4'b0100, rsp_result_o=3.75 (matches alu_model_pkg::num_add), ops_done_o=1.
- All four request simultaneously from reset with distinct operands (1+1, 2+2, 3+3, 4+4) → grants in order 0,1,2,3 with results 2,4,6,8, each routed only to its owner.
- Round-robin wrap: last_grant=3, reqs 0 and 3 both valid → 0 granted, then 3.
- Requester backpressure: owner holds rsp_ready_i=0 for 5 cycles → rsp_result_o stable, no new grant, busy_o=1 throughout.
- ALU backpressure: alu_in_ready_i=0 for 3 cycles, then alu_out_valid_i delayed 4 cycles → alu_left_o stable, no extra issue; sum -7 + 7 → 0.
- Reset asserted in WAIT → next cycle all outputs 0, state IDLE, no rsp_valid_o; a subsequent request completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: number format, scheduler states and default sizing.
package calc_pkg;

  localparam int unsigned NumReqDefault = 4;

  // Binary32-style number; the scheduler never looks inside it.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } num_t;

  localparam int unsigned NumW = $bits(num_t);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

endpackage

// File: rtl/calc_rr_arbiter.sv
// Combinational round-robin arbiter: first set request after last_grant, wrapping.
module calc_rr_arbiter #(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_grant,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx,
  output logic              any_req
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    any_req   = |req;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxW'((32'(last_grant) + i) % NumReq);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_add_sched.sv
// Shares one alu_add between NumReq requesters; round-robin accept, result returned to owner.
module alu_add_sched
  import calc_pkg::*;
#(
  parameter  int unsigned NumReq = NumReqDefault,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  num_t [NumReq-1:0]       req_left_i,
  input  num_t [NumReq-1:0]       req_right_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  output num_t                    rsp_result_o,
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i,
  output num_t                    alu_left_o,
  output num_t                    alu_right_o,
  output logic                    alu_in_valid_o,
  input  logic                    alu_in_ready_i,
  input  num_t                    alu_result_i,
  input  logic                    alu_out_valid_i,
  output logic                    alu_out_ready_o,
  output logic                    busy_o,
  output logic [31:0]             ops_done_o
);

  sched_state_e    state_q, state_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [IdxW-1:0] owner_q, owner_d;
  num_t            left_q, left_d;
  num_t            right_q, right_d;
  num_t            result_q, result_d;
  logic [31:0]     ops_done_q, ops_done_d;

  logic [NumReq-1:0] grant;
  logic [IdxW-1:0]   grant_idx;
  logic              any_req;

  calc_rr_arbiter #(
    .NumReq(NumReq)
  ) u_arb (
    .req       (req_valid_i),
    .last_grant(last_grant_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= IdxW'(NumReq - 1);
      owner_q      <= '0;
      left_q       <= '0;
      right_q      <= '0;
      result_q     <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      left_q       <= left_d;
      right_q      <= right_d;
      result_q     <= result_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // Handshake strobes decode from the registered state; only req_ready_o follows inputs.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    left_d          = left_q;
    right_d         = right_q;
    result_d        = result_q;
    ops_done_d      = ops_done_q;
    req_ready_o     = '0;
    alu_in_valid_o  = 1'b0;
    alu_out_ready_o = 1'b0;
    rsp_valid_o     = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req && rst_ni) begin
          req_ready_o = grant;
          owner_d     = grant_idx;
          left_d      = req_left_i[grant_idx];
          right_d     = req_right_i[grant_idx];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        alu_in_valid_o = 1'b1;
        if (alu_in_ready_i) state_d = WAIT;
      end
      WAIT: begin
        alu_out_ready_o = 1'b1;
        if (alu_out_valid_i) begin
          result_d = alu_result_i;
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) begin
          last_grant_d = owner_q;
          ops_done_d   = ops_done_q + 32'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_left_o   = left_q;
  assign alu_right_o  = right_q;
  assign rsp_result_o = result_q;
  assign busy_o       = (state_q != IDLE);
  assign ops_done_o   = ops_done_q;

  a_req_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_rsp_valid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o));
  a_phase_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({alu_in_valid_o, alu_out_ready_o, |rsp_valid_o}));

endmodule

// File: tb/tb_alu_add_sched.sv
// Directed bench for alu_add_sched with a behavioural alu_add stand-in.
module tb_alu_add_sched;
  import calc_pkg::*;

  localparam num_t V0    = num_t'(32'h0000_0000);
  localparam num_t V0_5  = num_t'(32'h3F00_0000);
  localparam num_t V1    = num_t'(32'h3F80_0000);
  localparam num_t V1_5  = num_t'(32'h3FC0_0000);
  localparam num_t V2    = num_t'(32'h4000_0000);
  localparam num_t V2_25 = num_t'(32'h4010_0000);
  localparam num_t V3    = num_t'(32'h4040_0000);
  localparam num_t V3_75 = num_t'(32'h4070_0000);
  localparam num_t V4    = num_t'(32'h4080_0000);
  localparam num_t V6    = num_t'(32'h40C0_0000);
  localparam num_t V7    = num_t'(32'h40E0_0000);
  localparam num_t VM7   = num_t'(32'hC0E0_0000);
  localparam num_t V8    = num_t'(32'h4100_0000);
  localparam num_t VBAD  = num_t'(32'h7FC0_0001);

  logic        clk_i, rst_ni;
  num_t [3:0]  req_left, req_right;
  logic [3:0]  req_valid, req_ready_o, rsp_valid_o, rsp_ready;
  num_t        rsp_result_o, alu_left_o, alu_right_o, alu_result;
  logic        alu_in_valid_o, alu_in_ready, alu_out_valid, alu_out_ready_o, busy_o;
  logic [31:0] ops_done_o;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_ops = 0;

  alu_add_sched #(.NumReq(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_left_i     (req_left),
    .req_right_i    (req_right),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .rsp_result_o   (rsp_result_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready),
    .alu_left_o     (alu_left_o),
    .alu_right_o    (alu_right_o),
    .alu_in_valid_o (alu_in_valid_o),
    .alu_in_ready_i (alu_in_ready),
    .alu_result_i   (alu_result),
    .alu_out_valid_i(alu_out_valid),
    .alu_out_ready_o(alu_out_ready_o),
    .busy_o         (busy_o),
    .ops_done_o     (ops_done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hand-computed sums for every operand pair the bench issues.
  function automatic num_t add_lut(input num_t l, input num_t r);
    if (l == V1_5 && r == V2_25) return V3_75;
    if (l == V1   && r == V1)    return V2;
    if (l == V2   && r == V2)    return V4;
    if (l == V3   && r == V3)    return V6;
    if (l == V4   && r == V4)    return V8;
    if (l == V1   && r == V2)    return V3;
    if (l == V0_5 && r == V0_5)  return V1;
    if (l == VM7  && r == V7)    return V0;
    return VBAD;
  endfunction

  // alu_add stand-in: decides at negedge what happens at the following posedge.
  int   stub_st = 0, in_stall = 0, out_delay = 0, stub_dly = 0, issues = 0;
  bit   in_fire_pend = 0, out_fire_pend = 0;
  num_t stub_res;

  initial begin
    alu_in_ready  = 1'b0;
    alu_out_valid = 1'b0;
    alu_result    = V0;
    stub_res      = V0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stub_st = 0; in_fire_pend = 0; out_fire_pend = 0;
        alu_in_ready = 1'b0; alu_out_valid = 1'b0;
      end else begin
        if (out_fire_pend) begin stub_st = 0; alu_out_valid = 1'b0; out_fire_pend = 0; end
        if (in_fire_pend) begin stub_st = 2; in_fire_pend = 0; end
        if (stub_st == 0) begin
          alu_in_ready = 1'b0;
          if (alu_in_valid_o) begin
            if (in_stall > 0) in_stall--;
            else begin
              alu_in_ready = 1'b1;
              in_fire_pend = 1;
              stub_res     = add_lut(alu_left_o, alu_right_o);
              stub_dly     = out_delay;
              issues++;
            end
          end
        end else begin
          alu_in_ready = 1'b0;
          if (stub_dly > 0) begin
            stub_dly--;
            alu_out_valid = 1'b0;
          end else begin
            alu_out_valid = 1'b1;
            alu_result    = stub_res;
            if (alu_out_ready_o) out_fire_pend = 1;
          end
        end
      end
    end
  end

  // Requesters hold valid until accepted, then drop it; grants are logged in order.
  int         grant_q[$];
  logic [3:0] acc_mask, hold_mask;

  initial begin
    hold_mask = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni) assert ((hold_mask & ~req_valid) == 4'b0) else $error("requester dropped valid early");
      acc_mask  = req_valid & req_ready_o;
      hold_mask = rst_ni ? (req_valid & ~acc_mask) : 4'b0;
      @(posedge clk_i);
      #2;
      if (rst_ni) begin
        req_valid = req_valid & ~acc_mask;
        for (int i = 0; i < 4; i++) if (acc_mask[i]) grant_q.push_back(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_valid = '0; rsp_ready = '0;
    tick(); tick();
    rst_ni = 1'b1;
  endtask

  task automatic send(input int idx, input num_t l, input num_t r);
    req_left[idx] = l; req_right[idx] = r; req_valid[idx] = 1'b1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid_o != 4'b0) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic give_rsp(input int idx);
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready = '0;
  endtask

  task automatic test_reset();
    req_left = '0; req_right = '0;
    do_reset();
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (ops_done_o !== 32'd0) begin n_fail++; $display("FAIL reset_ops: got %0d want 0", ops_done_o); end
    n_cmp++; if ({req_ready_o, rsp_valid_o, alu_in_valid_o, alu_out_ready_o} !== 10'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0", {req_ready_o, rsp_valid_o, alu_in_valid_o, alu_out_ready_o}); end
    n_cmp++; if ({rsp_result_o, alu_left_o, alu_right_o} !== 96'b0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {rsp_result_o, alu_left_o, alu_right_o}); end
  endtask

  task automatic test_single();
    bit ok;
    tick();
    send(2, V1_5, V2_25);
    #1;
    n_cmp++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready_o); end
    tick();
    n_cmp++; if (alu_in_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_issue: got %b want 1", alu_in_valid_o); end
    n_cmp++; if ({alu_left_o, alu_right_o} !== {V1_5, V2_25}) begin
      n_fail++; $display("FAIL single_operands: got %h want %h", {alu_left_o, alu_right_o}, {V1_5, V2_25}); end
    wait_rsp(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout: no response"); end
    n_cmp++; if (rsp_valid_o !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid_o); end
    n_cmp++; if (rsp_result_o !== V3_75) begin n_fail++; $display("FAIL single_result: got %h want %h", rsp_result_o, V3_75); end
    give_rsp(2);
    exp_ops++;
    n_cmp++; if (ops_done_o !== 32'(exp_ops)) begin n_fail++; $display("FAIL single_ops: got %0d want %0d", ops_done_o, exp_ops); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_all_four();
    bit   ok;
    num_t exp_res[4];
    exp_res[0] = V2; exp_res[1] = V4; exp_res[2] = V6; exp_res[3] = V8;
    do_reset();
    exp_ops = 0;
    grant_q.delete();
    tick();
    send(0, V1, V1); send(1, V2, V2); send(2, V3, V3); send(3, V4, V4);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL all4_timeout: op %0d", k); end
      n_cmp++; if (rsp_valid_o !== 4'(1 << k)) begin n_fail++; $display("FAIL all4_owner: op %0d got %b want %b", k, rsp_valid_o, 4'(1 << k)); end
      n_cmp++; if (rsp_result_o !== exp_res[k]) begin n_fail++; $display("FAIL all4_result: op %0d got %h want %h", k, rsp_result_o, exp_res[k]); end
      give_rsp(k);
      exp_ops++;
    end
    n_cmp++; if (grant_q.size() != 4) begin n_fail++; $display("FAIL all4_grants: got %0d grants want 4", grant_q.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_cmp++; if (grant_q[k] != k) begin n_fail++; $display("FAIL all4_order: slot %0d got %0d want %0d", k, grant_q[k], k); end
    end
    n_cmp++; if (ops_done_o !== 32'(exp_ops)) begin n_fail++; $display("FAIL all4_ops: got %0d want %0d", ops_done_o, exp_ops); end
  endtask

  task automatic test_rr_wrap();
    bit ok;
    grant_q.delete();
    send(0, V0_5, V0_5); send(3, V1, V2);
    wait_rsp(ok);
    n_cmp++; if (rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL wrap_first: got %b want 0001", rsp_valid_o); end
    n_cmp++; if (rsp_result_o !== V1) begin n_fail++; $display("FAIL wrap_first_result: got %h want %h", rsp_result_o, V1); end
    give_rsp(0);
    wait_rsp(ok);
    n_cmp++; if (rsp_valid_o !== 4'b1000) begin n_fail++; $display("FAIL wrap_second: got %b want 1000", rsp_valid_o); end
    n_cmp++; if (rsp_result_o !== V3) begin n_fail++; $display("FAIL wrap_second_result: got %h want %h", rsp_result_o, V3); end
    give_rsp(3);
    exp_ops += 2;
    n_cmp++; if (grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 3) begin
      n_fail++; $display("FAIL wrap_order: got %p want '{0, 3}", grant_q); end
  endtask

  task automatic test_rsp_backpressure();
    bit ok;
    send(1, V1, V2);
    tick();
    send(0, V0_5, V0_5);
    wait_rsp(ok);
    n_cmp++; if (rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL bp_owner: got %b want 0010", rsp_valid_o); end
    rsp_ready = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (rsp_valid_o !== 4'b0010 || rsp_result_o !== V3) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d got %b/%h want 0010/%h", c, rsp_valid_o, rsp_result_o, V3); end
      n_cmp++; if (busy_o !== 1'b1 || req_ready_o !== 4'b0) begin
        n_fail++; $display("FAIL bp_no_grant: cycle %0d busy %b ready %b want 1/0000", c, busy_o, req_ready_o); end
    end
    rsp_ready = '0;
    give_rsp(1);
    wait_rsp(ok);
    n_cmp++; if (rsp_valid_o !== 4'b0001 || rsp_result_o !== V1) begin
      n_fail++; $display("FAIL bp_next: got %b/%h want 0001/%h", rsp_valid_o, rsp_result_o, V1); end
    give_rsp(0);
    exp_ops += 2;
    n_cmp++; if (ops_done_o !== 32'(exp_ops)) begin n_fail++; $display("FAIL bp_ops: got %0d want %0d", ops_done_o, exp_ops); end
  endtask

  task automatic test_alu_backpressure();
    int iss0, n_in, n_out;
    iss0 = issues; n_in = 0; n_out = 0;
    in_stall = 3; out_delay = 4;
    send(3, VM7, V7);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (alu_in_valid_o) begin
        n_in++;
        n_cmp++; if ({alu_left_o, alu_right_o} !== {VM7, V7}) begin
          n_fail++; $display("FAIL alubp_stable: got %h want %h", {alu_left_o, alu_right_o}, {VM7, V7}); end
      end
      if (alu_out_ready_o) n_out++;
      if (rsp_valid_o != 4'b0) break;
    end
    n_cmp++; if (rsp_valid_o !== 4'b1000 || rsp_result_o !== V0) begin
      n_fail++; $display("FAIL alubp_result: got %b/%h want 1000/%h", rsp_valid_o, rsp_result_o, V0); end
    n_cmp++; if (n_in != 4) begin n_fail++; $display("FAIL alubp_issue_cycles: got %0d want 4", n_in); end
    n_cmp++; if (n_out != 5) begin n_fail++; $display("FAIL alubp_wait_cycles: got %0d want 5", n_out); end
    n_cmp++; if (issues - iss0 != 1) begin n_fail++; $display("FAIL alubp_issues: got %0d want 1", issues - iss0); end
    give_rsp(3);
    exp_ops++;
    out_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    out_delay = 10;
    send(0, V1, V1);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (alu_out_ready_o) break;
    end
    n_cmp++; if (alu_out_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_wait: got %b want 1", alu_out_ready_o); end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    exp_ops = 0;
    n_cmp++; if ({busy_o, req_ready_o, rsp_valid_o, alu_in_valid_o, alu_out_ready_o} !== 11'b0) begin
      n_fail++; $display("FAIL rmid_strobes: got %b want 0", {busy_o, req_ready_o, rsp_valid_o, alu_in_valid_o, alu_out_ready_o}); end
    n_cmp++; if (ops_done_o !== 32'd0 || rsp_result_o !== V0 || alu_left_o !== V0) begin
      n_fail++; $display("FAIL rmid_data: ops %0d result %h left %h want 0", ops_done_o, rsp_result_o, alu_left_o); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid_o != 4'b0 || busy_o) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rmid_ghost: got %0d active cycles want 0", seen); end
    out_delay = 0;
    send(2, V2, V2);
    wait_rsp(ok);
    n_cmp++; if (rsp_valid_o !== 4'b0100 || rsp_result_o !== V4) begin
      n_fail++; $display("FAIL rmid_after: got %b/%h want 0100/%h", rsp_valid_o, rsp_result_o, V4); end
    give_rsp(2);
    exp_ops++;
    n_cmp++; if (ops_done_o !== 32'(exp_ops)) begin n_fail++; $display("FAIL rmid_ops: got %0d want %0d", ops_done_o, exp_ops); end
  endtask

  initial begin
    rst_ni = 1'b0; req_valid = '0; rsp_ready = '0;
    test_reset();
    test_single();
    test_all_four();
    test_rr_wrap();
    test_rsp_backpressure();
    test_alu_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
